branch_global_lookup: RTL

- Prediction (read) side of the global-history branch predictor.
- Owns the Pattern History Table (PHT) of 2-bit saturating counters and the Global Branch Register (GBR).
- Serves fetch-stage prediction requests over a val/rdy request/response pair.
- Applies counter writes and GBR shifts issued by the update-side control, so lookup and update share one storage point.

---
 rtl/branch_global_lookup_if.sv | 30 +++
 rtl/branch_global_lookup.sv | 133 +++++++++++++
 2 files changed

// File: rtl/branch_global_lookup_if.sv
// Request/response and update signal bundle for the global-history predictor lookup block.
// The master drives requests and updates. The slave is the lookup block.
interface branch_global_lookup_if #(
    parameter int PHT_size = 2048
);
    localparam int IDX_W = $clog2(PHT_size);

    logic             req_val;
    logic             req_rdy;
    logic [31:0]      req_pc;
    logic             resp_val;
    logic             resp_rdy;
    logic             resp_taken;
    logic [IDX_W-1:0] resp_idx;
    logic             upd_wen;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_cnt;
    logic             gbr_shift;
    logic             gbr_bit;

    modport master (
        output req_val, req_pc, resp_rdy, upd_wen, upd_idx, upd_cnt, gbr_shift, gbr_bit,
        input  req_rdy, resp_val, resp_taken, resp_idx
    );

    modport slave (
        input  req_val, req_pc, resp_rdy, upd_wen, upd_idx, upd_cnt, gbr_shift, gbr_bit,
        output req_rdy, resp_val, resp_taken, resp_idx
    );
endinterface

// File: rtl/branch_global_lookup.sv
// Prediction side of a gshare-style predictor. It owns the PHT of 2-bit counters and the global branch register.
// Lookups run through IDLE/READ/RESP. Counter writes and GBR shifts from the update side apply in any state.
module branch_global_lookup #(
    parameter int PHT_size = 2048
) (
    input logic                   clk,
    input logic                   reset,
    branch_global_lookup_if.slave bus
);
    localparam int IDX_W = $clog2(PHT_size);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [IDX_W-1:0] gbr_r;
    logic [IDX_W-1:0] gbr_next_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next_s;
    logic             resp_taken_r;
    logic             resp_taken_next_s;
    logic [IDX_W-1:0] resp_idx_r;
    logic [IDX_W-1:0] resp_idx_next_s;
    logic [1:0]       pht_r [PHT_size];
    logic             bypass_s;
    logic             rd_taken_s;
    logic             pc_unused_s;

    function automatic logic [IDX_W-1:0] hash_idx(input logic [IDX_W-1:0] pc_bits,
                                                  input logic [IDX_W-1:0] history);
        return pc_bits ^ history;
    endfunction

    assign pc_unused_s = ^{bus.req_pc[31:IDX_W+2], bus.req_pc[1:0]};

    assign bus.req_rdy    = (state_r == IDLE) & ~reset;
    assign bus.resp_val   = (state_r == RESP);
    assign bus.resp_taken = resp_taken_r;
    assign bus.resp_idx   = resp_idx_r;

    // Write-first read of the PHT: a same-cycle write to the entry being read wins.
    always_comb begin
        bypass_s   = bus.upd_wen & (bus.upd_idx == idx_r);
        rd_taken_s = 1'b0;
        if (bypass_s) begin
            rd_taken_s = bus.upd_cnt[1];
        end else begin
            rd_taken_s = pht_r[idx_r][1];
        end
    end

    // Next GBR value. The shift drops the MSB.
    always_comb begin
        gbr_next_s = gbr_r;
        if (bus.gbr_shift) begin
            gbr_next_s = {gbr_r[IDX_W-2:0], bus.gbr_bit};
        end else begin
            gbr_next_s = gbr_r;
        end
    end

    // Lookup FSM next-state and datapath decode.
    always_comb begin
        state_next_s      = state_r;
        idx_next_s        = idx_r;
        resp_taken_next_s = resp_taken_r;
        resp_idx_next_s   = resp_idx_r;
        case (state_r)
            IDLE: begin
                if (bus.req_val) begin
                    idx_next_s   = hash_idx(bus.req_pc[IDX_W+1:2], gbr_r);
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ: begin
                resp_taken_next_s = rd_taken_s;
                resp_idx_next_s   = idx_r;
                state_next_s      = RESP;
            end
            RESP: begin
                if (bus.resp_rdy) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state, latched index and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= {IDX_W{1'b0}};
            resp_taken_r <= 1'b0;
            resp_idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            resp_taken_r <= resp_taken_next_s;
            resp_idx_r   <= resp_idx_next_s;
        end
    end

    // Global branch register.
    always_ff @(posedge clk) begin
        if (reset) begin
            gbr_r <= {IDX_W{1'b0}};
        end else begin
            gbr_r <= gbr_next_s;
        end
    end

    // PHT storage. Counters are written exactly as the update side supplies them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_size; i++) begin
                pht_r[i] <= 2'b01;
            end
        end else if (bus.upd_wen) begin
            pht_r[bus.upd_idx] <= bus.upd_cnt;
        end
    end
endmodule
